// File: rtl/uart_program_loader.sv
// uart_program_loader: boot-time loader for the CPU's instruction/data RAM.
// Receives an 8N1 serial image (16-bit big-endian length, then big-endian
// 16-bit words), writes each word through a RAM write port, and holds the
// CPU stalled until the full image has been written.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int unsigned MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    // Last counter value of the half-bit wait (start-bit centre) and of a full bit.
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_LEN_HI,
        L_LEN_LO,
        L_DATA_HI,
        L_DATA_LO,
        L_DONE,
        L_ERR
    } ld_state_t;

    logic        rx_meta;
    logic        rx_sync;

    rx_state_t   r_state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        byte_valid;
    logic        frame_err;

    ld_state_t   l_state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  data_hi;
    logic [15:0] index;
    logic [15:0] len_next;
    logic [15:0] index_next;

    // Two-flop synchronizer for the asynchronous serial input, preset to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit receiver: start-bit validation, 8 LSB-first data bits, stop-bit check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= R_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (!rx_sync) begin
                        clk_cnt <= '0;
                        r_state <= R_START;
                    end
                end
                R_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rx_sync) begin
                            bit_idx <= '0;
                            r_state <= R_DATA;
                        end else begin
                            r_state <= R_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                R_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            r_state <= R_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                R_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= R_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Candidate length and next word index used by the loader decisions.
    always_comb begin
        len_next   = {len_hi, shift};
        index_next = index + 16'd1;
    end

    // Word loader: parses the header, issues one RAM write per word, tracks done/err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_state      <= L_LEN_HI;
            len_hi       <= '0;
            len          <= '0;
            data_hi      <= '0;
            index        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_data     <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (l_state)
                L_LEN_HI: begin
                    if (frame_err) begin
                        l_state <= L_ERR;
                    end else if (byte_valid) begin
                        len_hi  <= shift;
                        l_state <= L_LEN_LO;
                    end
                end
                L_LEN_LO: begin
                    if (frame_err) begin
                        l_state <= L_ERR;
                    end else if (byte_valid) begin
                        len <= len_next;
                        if (len_next == 16'd0) begin
                            l_state <= L_DONE;
                        end else if (32'(len_next) > MAX_WORDS) begin
                            l_state <= L_ERR;
                        end else begin
                            l_state <= L_DATA_HI;
                        end
                    end
                end
                L_DATA_HI: begin
                    if (frame_err) begin
                        l_state <= L_ERR;
                    end else if (byte_valid) begin
                        data_hi <= shift;
                        l_state <= L_DATA_LO;
                    end
                end
                L_DATA_LO: begin
                    if (frame_err) begin
                        l_state <= L_ERR;
                    end else if (byte_valid) begin
                        mem_we       <= 1'b1;
                        mem_data     <= {data_hi, shift};
                        mem_addr     <= BASE_ADDR + index;
                        index        <= index_next;
                        words_loaded <= words_loaded + 16'd1;
                        if (index_next == len) begin
                            l_state <= L_DONE;
                        end else begin
                            l_state <= L_DATA_HI;
                        end
                    end
                end
                // Entered on the write-issue edge, so release lands after the final mem_we cycle.
                L_DONE: begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                L_ERR: begin
                    err      <= 1'b1;
                    cpu_hold <= 1'b1;
                end
                default: l_state <= L_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard testbench for uart_program_loader: expected RAM writes are queued
// by the stimulus, and a monitor pops/compares on every mem_we cycle.
module tb_uart_program_loader;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic reset;
    logic rx_a, rx_b;

    logic        mem_we_a, mem_we_b;
    logic [15:0] mem_addr_a, mem_addr_b;
    logic [15:0] mem_data_a, mem_data_b;
    logic        cpu_hold_a, cpu_hold_b;
    logic        done_a, done_b;
    logic        err_a, err_b;
    logic [15:0] words_loaded_a, words_loaded_b;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] e_a, e_b;

    always #5 clk = ~clk;

    // Instance A: base address 0, small MAX_WORDS for the over-length case.
    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR(16'h0000),
        .MAX_WORDS(4)
    ) dut_a (
        .clk(clk),
        .reset(reset),
        .rx(rx_a),
        .mem_we(mem_we_a),
        .mem_addr(mem_addr_a),
        .mem_data(mem_data_a),
        .cpu_hold(cpu_hold_a),
        .done(done_a),
        .err(err_a),
        .words_loaded(words_loaded_a)
    );

    // Instance B: base address at the top of the space to exercise wrap.
    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR(16'hFFFF),
        .MAX_WORDS(1024)
    ) dut_b (
        .clk(clk),
        .reset(reset),
        .rx(rx_b),
        .mem_we(mem_we_b),
        .mem_addr(mem_addr_b),
        .mem_data(mem_data_b),
        .cpu_hold(cpu_hold_b),
        .done(done_b),
        .err(err_b),
        .words_loaded(words_loaded_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the head of its expected queue.
    always @(negedge clk) begin
        if (mem_we_a) begin
            vectors++;
            if (exp_a.size() == 0) begin
                miscompares++;
                $display("FAIL write_a: got addr %h data %h expected no write", mem_addr_a, mem_data_a);
            end else begin
                e_a = exp_a.pop_front();
                if ({mem_addr_a, mem_data_a} !== e_a) begin
                    miscompares++;
                    $display("FAIL write_a: got addr %h data %h expected addr %h data %h",
                             mem_addr_a, mem_data_a, e_a[31:16], e_a[15:0]);
                end
            end
        end
        if (mem_we_b) begin
            vectors++;
            if (exp_b.size() == 0) begin
                miscompares++;
                $display("FAIL write_b: got addr %h data %h expected no write", mem_addr_b, mem_data_b);
            end else begin
                e_b = exp_b.pop_front();
                if ({mem_addr_b, mem_data_b} !== e_b) begin
                    miscompares++;
                    $display("FAIL write_b: got addr %h data %h expected addr %h data %h",
                             mem_addr_b, mem_data_b, e_b[31:16], e_b[15:0]);
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_val);
        drive(sel, 1'b0);
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            repeat (CPB) @(posedge clk);
        end
        drive(sel, stop_val);
        repeat (CPB) @(posedge clk);
        drive(sel, 1'b1);
    endtask

    task automatic send_seq(input int sel, input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(sel, bytes[i], 1'b1);
    endtask

    // Returns on the negedge where mem_we is high; a timeout counts as a failure.
    task automatic wait_we(input int sel, input string name);
        int n = 0;
        while (!((sel == 0) ? mem_we_a : mem_we_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no mem_we within 200 cycles expected a write", name);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        apply_reset();

        // Reset state.
        check("rst_we",    {15'd0, mem_we_a},   16'd0);
        check("rst_addr",  mem_addr_a,          16'h0000);
        check("rst_addr_b", mem_addr_b,         16'hFFFF);
        check("rst_data",  mem_data_a,          16'h0000);
        check("rst_hold",  {15'd0, cpu_hold_a}, 16'd1);
        check("rst_done",  {15'd0, done_a},     16'd0);
        check("rst_err",   {15'd0, err_a},      16'd0);
        check("rst_words", words_loaded_a,      16'd0);

        // Base load: two words.
        exp_a.push_back({16'h0000, 16'h1234});
        exp_a.push_back({16'h0001, 16'hABCD});
        send_seq(0, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
        wait_we(0, "base_last_we");
        check("base_done_during_we", {15'd0, done_a},     16'd0);
        check("base_hold_during_we", {15'd0, cpu_hold_a}, 16'd1);
        @(negedge clk);
        check("base_done",  {15'd0, done_a},     16'd1);
        check("base_hold",  {15'd0, cpu_hold_a}, 16'd0);
        check("base_words", words_loaded_a,      16'd2);
        check("base_err",   {15'd0, err_a},      16'd0);
        // Bytes after completion are ignored.
        send_seq(0, '{8'h77, 8'h88});
        repeat (10) @(negedge clk);
        check("base_words_after", words_loaded_a, 16'd2);

        // Zero length.
        apply_reset();
        send_seq(0, '{8'h00, 8'h00});
        repeat (4) @(negedge clk);
        check("zero_done",  {15'd0, done_a},     16'd1);
        check("zero_hold",  {15'd0, cpu_hold_a}, 16'd0);
        check("zero_words", words_loaded_a,      16'd0);

        // Over-length (MAX_WORDS=4, len=5).
        apply_reset();
        send_seq(0, '{8'h00, 8'h05});
        repeat (6) @(negedge clk);
        check("over_err",  {15'd0, err_a},      16'd1);
        check("over_hold", {15'd0, cpu_hold_a}, 16'd1);
        check("over_done", {15'd0, done_a},     16'd0);
        send_seq(0, '{8'h11, 8'h22});
        repeat (10) @(negedge clk);
        check("over_words", words_loaded_a, 16'd0);

        // Framing error on the low data byte.
        apply_reset();
        send_seq(0, '{8'h00, 8'h01, 8'h12});
        send_byte(0, 8'h34, 1'b0);
        repeat (60) @(negedge clk);
        check("frame_err",   {15'd0, err_a},      16'd1);
        check("frame_hold",  {15'd0, cpu_hold_a}, 16'd1);
        check("frame_done",  {15'd0, done_a},     16'd0);
        check("frame_words", words_loaded_a,      16'd0);

        // Reset mid-load, then a fresh one-word load.
        apply_reset();
        exp_a.push_back({16'h0000, 16'h1234});
        send_seq(0, '{8'h00, 8'h03, 8'h12, 8'h34});
        wait_we(0, "mid_first_we");
        repeat (3) @(negedge clk);
        apply_reset();
        check("mid_rst_words", words_loaded_a, 16'd0);
        check("mid_rst_addr",  mem_addr_a,     16'h0000);
        exp_a.push_back({16'h0000, 16'h55AA});
        send_seq(0, '{8'h00, 8'h01, 8'h55, 8'hAA});
        wait_we(0, "mid_reload_we");
        @(negedge clk);
        check("mid_done",  {15'd0, done_a}, 16'd1);
        check("mid_words", words_loaded_a,  16'd1);

        // Glitch then address wrap on instance B.
        @(posedge clk);
        rx_b = 1'b0;
        @(posedge clk);
        rx_b = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_words", words_loaded_b, 16'd0);
        exp_b.push_back({16'hFFFF, 16'h0001});
        exp_b.push_back({16'h0000, 16'h0002});
        send_seq(1, '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02});
        wait_we(1, "wrap_last_we");
        @(negedge clk);
        check("wrap_done",  {15'd0, done_b}, 16'd1);
        check("wrap_words", words_loaded_b,  16'd2);

        repeat (5) @(negedge clk);
        check("exp_a_drained", 16'(exp_a.size()), 16'd0);
        check("exp_b_drained", 16'(exp_b.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
